// File: rtl/rvv_defs.sv
// rvv_defs: shared types and constants for the vector instruction sequencer
package rvv_defs;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} seq_state_t;
  localparam logic [6:0] RVV_OPC_STORE = 7'b0100111;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] vl;
  } seq_entry_t;
endpackage

// File: rtl/rvv_sync_fifo.sv
// rvv_sync_fifo: power-of-two synchronous FIFO with full/empty flags and synchronous clear
module rvv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/rvv_vector_sequencer.sv
// rvv_vector_sequencer: buffers vector instructions and sequences issue, completion and writeback
module rvv_vector_sequencer
  import rvv_defs::*;
#(
  parameter int VLEN = 512,
  parameter int NUM_REGS = 32,
  parameter int QDEPTH = 4,
  parameter int TIMEOUT = 1024,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_vl,
  input  logic            flush,
  output logic            issue_start,
  output logic [31:0]     issue_instr,
  output logic [31:0]     issue_vl,
  input  logic            core_done,
  input  logic [VLEN-1:0] core_result,
  output logic            core_rst_n,
  output logic            wb_we,
  output logic [RW-1:0]   wb_addr,
  output logic [VLEN-1:0] wb_data,
  output logic            retire,
  output logic            timeout_err,
  output logic            busy
);
  localparam int CW = $clog2(TIMEOUT);
  seq_state_t state_q, state_d;
  seq_entry_t fifo_out;
  logic fifo_full, fifo_empty, push, pop;
  logic [31:0] instr_q, instr_d, vl_q, vl_d;
  logic [VLEN-1:0] result_q, result_d, wb_data_q, wb_data_d;
  logic [RW-1:0] wb_addr_q, wb_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue_start_q, issue_start_d, wb_we_q, wb_we_d, retire_q, retire_d;
  logic timeout_err_q, timeout_err_d, core_rst_n_q, core_rst_n_d;
  assign in_ready = rst && !fifo_full && !flush;
  assign push = in_valid && in_ready;
  assign busy = !fifo_empty || state_q != S_IDLE;
  rvv_sync_fifo #(.WIDTH($bits(seq_entry_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .push(push),
    .pop(pop),
    .wdata({in_instr, in_vl}),
    .rdata(fifo_out),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    vl_d = vl_q;
    result_d = result_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    cnt_d = cnt_q;
    issue_start_d = 1'b0;
    wb_we_d = 1'b0;
    retire_d = 1'b0;
    core_rst_n_d = 1'b1;
    timeout_err_d = timeout_err_q;
    pop = 1'b0;
    if (flush) begin
      // abandoning work the core has already seen needs a core reset
      state_d = S_IDLE;
      core_rst_n_d = !(state_q == S_ISSUE || state_q == S_WAIT);
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) begin
          pop = 1'b1;
          instr_d = fifo_out.instr;
          vl_d = fifo_out.vl;
          retire_d = fifo_out.vl == '0;
          state_d = fifo_out.vl == '0 ? S_IDLE : S_ISSUE;
        end
        S_ISSUE: begin
          issue_start_d = 1'b1;
          cnt_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: if (core_done) begin
          result_d = core_result;
          state_d = S_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          core_rst_n_d = 1'b0;
          timeout_err_d = 1'b1;
          retire_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        S_WB: begin
          wb_we_d = instr_q[6:0] != RVV_OPC_STORE;
          wb_addr_d = RW'(instr_q[11:7]);
          wb_data_d = result_q;
          retire_d = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      vl_q <= '0;
      result_q <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      cnt_q <= '0;
      issue_start_q <= 1'b0;
      wb_we_q <= 1'b0;
      retire_q <= 1'b0;
      timeout_err_q <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      vl_q <= vl_d;
      result_q <= result_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      cnt_q <= cnt_d;
      issue_start_q <= issue_start_d;
      wb_we_q <= wb_we_d;
      retire_q <= retire_d;
      timeout_err_q <= timeout_err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end
  assign issue_start = issue_start_q;
  assign issue_instr = instr_q;
  assign issue_vl = vl_q;
  assign core_rst_n = core_rst_n_q;
  assign wb_we = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign retire = retire_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: doc/rvv_vector_sequencer.md
# rvv_vector_sequencer

Parametrised instruction sequencer that sits between the scalar-side instruction source and the vector decode/regfile/core datapath. It buffers incoming vector instructions, issues them one at a time with a start/done handshake, and owns register-file writeback. It adds behaviour the previous system top lacked: back-pressure, a hang watchdog with core-only reset, a synchronous flush, and `vl == 0` elision.

## Interface
- `VLEN`, 512, vector register width in bits (result and writeback data width).
- `NUM_REGS`, 32, architectural vector registers; `RW = $clog2(NUM_REGS)`.
- `QDEPTH`, 4, instruction FIFO depth; must be a power of 2 and at least 2.
- `TIMEOUT`, 1024, WAIT cycles before the watchdog fires; at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: instruction push handshake.
- `in_instr` in 32 / `in_vl` in 32: instruction word and its vector length.
- `flush` in 1: synchronous abort of queued and in-flight work.
- `issue_start` out 1: single-cycle start pulse to the core.
- `issue_instr` out 32 / `issue_vl` out 32: current instruction, held stable from ISSUE through WB.
- `core_done` in 1: core completion (the core's `ready`).
- `core_result` in VLEN: core output, sampled on `core_done`.
- `core_rst_n` out 1: active-low core-only reset (feeds the ALU reset).
- `wb_we` out 1 / `wb_addr` out RW / `wb_data` out VLEN: register-file write port.
- `retire` out 1: single-cycle pulse per completed or elided instruction.
- `timeout_err` out 1: sticky; cleared only by `rst`.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- **FIFO**
  - Entries are {instr, vl}.
  - `in_ready = !full && !flush`; there is no same-cycle pass-through.
  - A push when full is impossible by construction.
- **FSM states:** IDLE, ISSUE, WAIT, WB.
  - IDLE: if the FIFO is non-empty, pop into the current registers.
    - If the popped `vl == 0`, stay in IDLE and pulse `retire` next cycle. No issue, no writeback.
    - Otherwise go to ISSUE.
  - ISSUE: `issue_start = 1` for exactly one cycle, then go to WAIT. The watchdog counter clears.
  - WAIT: the counter increments each cycle.
    - `core_done` → latch `core_result`, go to WB.
    - Counter reaches `TIMEOUT-1` without done → drive `core_rst_n` low for one cycle, set `timeout_err`, pulse `retire`, and go to IDLE with no writeback.
  - WB:
    - `wb_we = 1` unless the instruction is a store (`instr[6:0] == 7'b0100111`).
    - `wb_addr = instr[11:7]` truncated or zero-extended to RW; `wb_data` is the latched result.
    - Pulse `retire`, then go to IDLE.
- **flush**
  - Empties the FIFO and forces IDLE.
  - Any push in the same cycle is dropped.
  - If flush occurs in ISSUE or WAIT, drive `core_rst_n` low for one cycle.
  - A flush in WB suppresses `wb_we`; no `retire` is issued for flushed work.
- **Simultaneity**
  - Push and pop in the same cycle are both honoured.
  - `core_done` arriving on the same edge the watchdog expires: done wins and the instruction writes back.
- **Error flag:** `timeout_err` does not stall the sequencer.

## Timing
- **Reset values:**
  - Low: `in_ready` (low during reset, 1 after), `issue_start`, `wb_we`, `retire`, `timeout_err`, `busy`.
  - `core_rst_n` = 0 during reset, 1 after.
  - Zero: `wb_addr`, `wb_data`, `issue_instr`, `issue_vl`. The FIFO is empty and the FSM is in IDLE.
- **Issue latency:** a push accepted at edge E0 into an empty, idle sequencer gives `issue_start` high in the cycle after E2.
- **Minimum occupancy:** ISSUE, WAIT and WB each take 1 cycle, so one instruction occupies at least 3 cycles from pop to retire.
- **Outputs:** all outputs are registered, except `in_ready` and `busy`, which are combinational from registered state and `flush`.
- **Reset mid-operation:** asynchronous. All state clears immediately and there is no writeback.

## Structure
- **Shared package (`rvv_defs`):**
  - `seq_state_t` enum.
  - `RVV_OPC_STORE` constant.
  - A `seq_entry_t` struct {instr, vl}.
- **Sub-module:** one natural sub-module, `rvv_sync_fifo`, parametrised on width and depth, with full/empty flags and a synchronous clear (used for flush).
- **Top-level integration:** the decoder, regfile and `rvv_vector_top` stay outside this block. The system top wires `issue_*`, `core_*` and `wb_*` to them.

## Test plan
- **Single op:** push `vadd` with vd=3, vl=16; core_done 2 cycles after start with result `'hA5`. Expect `wb_we` with `wb_addr=3`, `wb_data='hA5`, one `retire`, and `issue_start` exactly 1 cycle wide.
- **Back-pressure:** with QDEPTH=4, hold `core_done` low and push 6 instructions back-to-back. Expect `in_ready` low after the 4th accept plus the one already popped, and all 5 accepted instructions to retire in order.
- **Store and vl=0:** a store opcode produces `retire` with no `wb_we`. `vl=0` produces `retire` with no `issue_start`, 1 cycle after the pop.
- **Watchdog:** with TIMEOUT=8 and `core_done` never asserted, expect `core_rst_n` low for 1 cycle after 8 WAIT cycles, `timeout_err` stuck at 1, and the next queued instruction to issue normally.
- **Flush:** flush in WAIT with 2 instructions queued and `in_valid` high. Expect the FIFO to empty, `core_rst_n` pulsed, no `retire`, no `wb_we`, the push dropped, and `busy` low on the next cycle.
- **Race and reset:** `core_done` on the watchdog-expiry edge results in writeback and no error. Asserting `rst` in WB clears all outputs immediately with no write.
